// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, ALU/memory select, register file
// write port, optional decode forwarding tap (WB_FWD_EN), saturating retire counter.
module wb_stage #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_mem_data,
  input  logic [ADDR_W-1:0] id_rs,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] write_reg_num,
  output logic [DATA_W-1:0] write_data,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retire_cnt
);

  logic              r_wb_valid;
  logic              r_wb_reg_write;
  logic [ADDR_W-1:0] r_wb_rd;
  logic [DATA_W-1:0] r_wb_data;
  logic [CNT_W-1:0]  r_retire_cnt;

  logic [DATA_W-1:0] w_wb_data_nxt;
  logic              w_cnt_sat;

  assign w_wb_data_nxt = ex_mem_to_reg ? ex_mem_data : ex_alu_result;
  assign w_cnt_sat     = &r_retire_cnt;

  // Flush beats stall; on flush the payload is held, only the qualifiers drop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_data      <= '0;
      r_retire_cnt   <= '0;
    end else if (flush) begin
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
    end else if (!stall) begin
      r_wb_valid     <= ex_valid;
      r_wb_reg_write <= ex_valid & ex_reg_write;
      r_wb_rd        <= ex_rd;
      r_wb_data      <= w_wb_data_nxt;
      if (ex_valid && !w_cnt_sat)
        r_retire_cnt <= r_retire_cnt + 1'b1;
    end
  end

  // Held asserted through a stall: the register file simply rewrites the same value.
  assign RegWrite      = r_wb_valid & r_wb_reg_write;
  assign write_reg_num = r_wb_rd;
  assign write_data    = r_wb_data;
  assign retire_cnt    = r_retire_cnt;

`ifdef WB_FWD_EN
  assign fwd_hit  = RegWrite & (r_wb_rd == id_rs);
  assign fwd_data = r_wb_data;
`else
  logic w_unused_rs;
  assign w_unused_rs = ^id_rs;
  assign fwd_hit     = 1'b0;
  assign fwd_data    = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic
// against a transaction-level reference model of the write-back stage.
module tb_wb_stage;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst, stall, flush, ex_valid, ex_reg_write, ex_mem_to_reg;
  logic [ADDR_W-1:0] ex_rd, id_rs;
  logic [DATA_W-1:0] ex_alu_result, ex_mem_data;
  logic              RegWrite, fwd_hit;
  logic [ADDR_W-1:0] write_reg_num;
  logic [DATA_W-1:0] write_data, fwd_data;
  logic [CNT_W-1:0]  retire_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the instruction currently sitting at the write port.
  bit pend_write;
  int pend_rd, pend_data, retired;

  wb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_rd(ex_rd), .ex_alu_result(ex_alu_result), .ex_mem_data(ex_mem_data),
    .id_rs(id_rs), .RegWrite(RegWrite), .write_reg_num(write_reg_num),
    .write_data(write_data), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit fwd_en();
`ifdef WB_FWD_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Advance one clock, apply the stage rules to the model, then settle past the edge.
  task automatic step();
    @(posedge clk);
    if (!rst) begin
      pend_write = 0; pend_rd = 0; pend_data = 0; retired = 0;
    end else if (flush) begin
      pend_write = 0;
    end else if (!stall) begin
      pend_write = ex_valid && ex_reg_write;
      pend_rd    = ex_rd;
      pend_data  = ex_mem_to_reg ? ex_mem_data : ex_alu_result;
      if (ex_valid) retired = (retired + 1 > CNT_MAX) ? CNT_MAX : retired + 1;
    end
    #1;
  endtask

  task automatic set_ex(bit v, bit we, bit m2r, int rd, int alu, int mem);
    ex_valid = v; ex_reg_write = we; ex_mem_to_reg = m2r;
    ex_rd = ADDR_W'(rd); ex_alu_result = DATA_W'(alu); ex_mem_data = DATA_W'(mem);
  endtask

  task automatic test_reset();
    rst = 0; stall = 0; flush = 0; id_rs = 0;
    set_ex(1, 1, 0, 7, 'hFF, 'hEE);
    step(); step();
    n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite got=%b exp=0", RegWrite); end
    n_checks++; if (write_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", write_data); end
    n_checks++; if (write_reg_num !== 3'd0) begin n_fail++; $display("FAIL reset_rd got=%0d exp=0", write_reg_num); end
    n_checks++; if (retire_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", retire_cnt); end
    n_checks++; if (fwd_hit !== 1'b0) begin n_fail++; $display("FAIL reset_fwd got=%b exp=0", fwd_hit); end
    rst = 1;
    set_ex(0, 1, 0, 7, 'hFF, 'hEE);
    step();
    n_checks++; if (RegWrite !== 1'b0 || retire_cnt !== 4'd0) begin
      n_fail++; $display("FAIL reset_release_bubble got we=%b cnt=%0d exp we=0 cnt=0", RegWrite, retire_cnt); end
  endtask

  task automatic test_alu_write();
    set_ex(1, 1, 0, 5, 'h3C, 'h00);
    step();
    n_checks++; if (RegWrite !== 1'b1 || write_reg_num !== 3'd5 || write_data !== 8'h3C || retire_cnt !== 4'd1) begin
      n_fail++; $display("FAIL alu_write got we=%b rd=%0d d=%h cnt=%0d exp we=1 rd=5 d=3c cnt=1",
                         RegWrite, write_reg_num, write_data, retire_cnt); end
  endtask

  task automatic test_mem_select();
    set_ex(1, 1, 1, 2, 'h11, 'hA7);
    step();
    n_checks++; if (write_data !== 8'hA7 || write_reg_num !== 3'd2 || RegWrite !== 1'b1) begin
      n_fail++; $display("FAIL mem_select got we=%b rd=%0d d=%h exp we=1 rd=2 d=a7", RegWrite, write_reg_num, write_data); end
    flush = 1; stall = 1;
    set_ex(1, 1, 0, 6, 'h42, 'h00);
    step();
    flush = 0; stall = 0;
    n_checks++; if (RegWrite !== 1'b0 || retire_cnt !== 4'd2) begin
      n_fail++; $display("FAIL flush_over_stall got we=%b cnt=%0d exp we=0 cnt=2", RegWrite, retire_cnt); end
  endtask

  task automatic test_stall();
    set_ex(1, 1, 0, 3, 'h55, 'h00);
    step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_ex(1, 1, $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255));
      step();
      n_checks++; if (RegWrite !== 1'b1 || write_reg_num !== 3'd3 || write_data !== 8'h55 || retire_cnt !== 4'd3) begin
        n_fail++; $display("FAIL stall_hold[%0d] got we=%b rd=%0d d=%h cnt=%0d exp we=1 rd=3 d=55 cnt=3",
                           i, RegWrite, write_reg_num, write_data, retire_cnt); end
    end
    stall = 0;
  endtask

  task automatic test_forward();
    set_ex(1, 1, 0, 4, 'h9E, 'h00);
    step();
    id_rs = 3'd4; #1;
    n_checks++; if (fwd_hit !== fwd_en() || fwd_data !== (fwd_en() ? 8'h9E : 8'h00)) begin
      n_fail++; $display("FAIL fwd_match got hit=%b d=%h exp hit=%b", fwd_hit, fwd_data, fwd_en()); end
    id_rs = 3'd6; #1;
    n_checks++; if (fwd_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_miss got hit=%b exp 0", fwd_hit); end
    set_ex(0, 1, 0, 4, 'h9E, 'h00);
    id_rs = 3'd4;
    step();
    n_checks++; if (RegWrite !== 1'b0 || fwd_hit !== 1'b0) begin
      n_fail++; $display("FAIL bubble got we=%b hit=%b exp we=0 hit=0", RegWrite, fwd_hit); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rst   = ($urandom_range(0, 39) != 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 5) == 0);
      set_ex($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
             $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255));
      id_rs = ADDR_W'($urandom_range(0, 7));
      step();
      n_checks++;
      if (RegWrite !== pend_write || retire_cnt !== CNT_W'(retired) ||
          (rst && write_reg_num !== ADDR_W'(pend_rd)) || (rst && write_data !== DATA_W'(pend_data)) ||
          fwd_hit !== (fwd_en() && pend_write && int'(id_rs) == pend_rd) ||
          fwd_data !== (fwd_en() ? DATA_W'(pend_data) : 8'h00)) begin
        n_fail++;
        $display("FAIL random[%0d] got we=%b rd=%0d d=%h cnt=%0d hit=%b fd=%h exp we=%b rd=%0d d=%h cnt=%0d",
                 i, RegWrite, write_reg_num, write_data, retire_cnt, fwd_hit, fwd_data,
                 pend_write, pend_rd, pend_data, retired);
      end
    end
    rst = 1; flush = 0; stall = 0;
  endtask

  task automatic test_saturation();
    rst = 0; step(); rst = 1;
    for (int i = 0; i < 20; i++) begin
      set_ex(1, $urandom_range(0, 1), 0, $urandom_range(0, 7), $urandom_range(0, 255), 0);
      step();
      n_checks++; if (retire_cnt !== CNT_W'(retired)) begin
        n_fail++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, retire_cnt, retired); end
    end
    n_checks++; if (retire_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_final got=%h exp=f", retire_cnt); end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_mem_select();
    test_stall();
    test_forward();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the 8-bit five-stage pipeline. Captures the EX/MEM result in the MEM/WB pipeline register, selects ALU or memory data, and drives the register file write port (RegWrite, write_reg_num, write_data). Provides a forwarding tap toward decode so a reader of the register file sees the in-flight value. Keeps a saturating count of retired instructions.

## Interface
- DATA_W, 8, datapath width; matches register file word width
- ADDR_W, 3, register index width (8 registers)
- CNT_W, 16, retire counter width
- clk  input  1  clock; all state updates on posedge
- rst  input  1  reset, synchronous, active-low
- stall  input  1  hold MEM/WB register contents
- flush  input  1  load a bubble into MEM/WB
- ex_valid  input  1  upstream holds a real instruction
- ex_reg_write  input  1  instruction writes a register
- ex_mem_to_reg  input  1  1 selects mem_data, 0 selects alu_result
- ex_rd  input  ADDR_W  destination register index
- ex_alu_result  input  DATA_W  ALU result
- ex_mem_data  input  DATA_W  data-memory read value
- id_rs  input  ADDR_W  decode-stage source index (same value as register file read_reg_num_1)
- RegWrite  output  1  register file write enable
- write_reg_num  output  ADDR_W  register file write index
- write_data  output  DATA_W  register file write data
- fwd_hit  output  1  id_rs matches pending write
- fwd_data  output  DATA_W  value to substitute on fwd_hit
- retire_cnt  output  CNT_W  count of valid instructions loaded

## Operation
- State: wb_valid, wb_reg_write, wb_rd, wb_data (registered, mux applied before the flop), retire_cnt.
- Per posedge, priority order:
  - !rst: wb_valid=0, wb_reg_write=0, wb_rd=0, wb_data=0, retire_cnt=0.
  - flush: wb_valid=0, wb_reg_write=0; wb_rd/wb_data don't-care but held; counter unchanged. Flush wins over stall.
  - stall: all state held; counter unchanged.
  - else: load wb_valid=ex_valid, wb_reg_write=ex_valid&ex_reg_write, wb_rd=ex_rd, wb_data = ex_mem_to_reg ? ex_mem_data : ex_alu_result. If ex_valid, retire_cnt+=1, saturating at 2^CNT_W-1 (no wrap).
- Outputs (combinational from state only):
  - RegWrite = wb_valid & wb_reg_write.
  - write_reg_num = wb_rd; write_data = wb_data.
- Writes to register 0 are performed; r0 is general-purpose.
- Register file write is level-sensitive; during stall RegWrite stays asserted and rewrites the same value. Harmless, required.

## Timing
- Latency: EX inputs to register file write port = 1 cycle.
- Outputs change only after posedge; no input-to-output combinational path except id_rs -> fwd_hit/fwd_data.
- All outputs 0 in the cycle following a !rst edge; rst low mid-stream discards the held instruction (no write).
- Bubble (ex_valid=0) yields RegWrite=0 next cycle regardless of ex_reg_write.
- Back-to-back valid instructions retire one per cycle; no internal stall generation.

## Configuration
- WB_FWD_EN defined: fwd_hit = RegWrite & (wb_rd == id_rs); fwd_data = wb_data. Same-cycle visibility for a decode read of the register being written.
- WB_FWD_EN undefined: fwd_hit tied 0, fwd_data tied 0; comparator not built. Decode relies on register file write-through only.

## Test plan
- Reset: hold rst=0 two cycles with ex_valid=1 -> RegWrite=0, write_data=0x00, retire_cnt=0; release -> first load occurs next edge.
- ALU write: ex_valid=1, ex_reg_write=1, ex_mem_to_reg=0, ex_rd=5, ex_alu_result=0x3C -> next cycle RegWrite=1, write_reg_num=5, write_data=0x3C, retire_cnt=1.
- Mem select: ex_mem_to_reg=1, ex_mem_data=0xA7, ex_alu_result=0x11, ex_rd=2 -> write_data=0xA7; then flush=1 & stall=1 together -> RegWrite=0 next cycle, retire_cnt unchanged.
- Stall hold: load rd=3 data=0x55, then stall=1 three cycles with new EX values -> outputs stay rd=3/0x55, RegWrite=1, counter unchanged.
- Forwarding (WB_FWD_EN): pending write rd=4 data=0x9E, id_rs=4 -> fwd_hit=1, fwd_data=0x9E; id_rs=6 -> fwd_hit=0; without macro -> fwd_hit=0 always.
- Saturation with CNT_W=4: 20 consecutive valid loads -> retire_cnt stops at 0xF.
